// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/halfword/word load-store engine with RMW sub-word stores
module mem_access_unit #(
  parameter int ADDR_W = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_write,
  output logic [31:0] m_addr,
  output logic [31:0] m_w_data,
  input  logic [31:0] m_r_data
);

  typedef enum logic [2:0] {IDLE, READ, CAPT, WRITE, RESP} state_t;

  state_t      state, state_n;
  logic        l_we;
  logic [1:0]  l_size;
  logic        l_uns;
  logic [1:0]  l_lane;
  logic [31:0] l_wdata;

  logic        accept;
  logic        req_bad;
  logic [4:0]  sh_amt;
  logic [31:0] shifted;
  logic [31:0] lane_mask;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign accept     = req_valid && req_ready;
  assign req_ready  = (state == IDLE) && rst;
  assign resp_valid = (state == RESP);
  // A reset asserted during WRITE must suppress the falling-edge write
  assign mem_write  = (state == WRITE) && rst;

  // Reject illegal size, misalignment and addresses beyond the memory
  always_comb begin
    req_bad = 1'b0;
    if (req_size == 2'b11) req_bad = 1'b1;
    if (req_size == 2'b01 && req_addr[0]) req_bad = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00) req_bad = 1'b1;
    if (req_addr[31:ADDR_W+2] != '0) req_bad = 1'b1;
  end

  // Lane extraction for loads and lane merge for sub-word stores (little-endian)
  always_comb begin
    sh_amt    = (l_size == 2'b00) ? {l_lane, 3'b000} : {l_lane[1], 4'b0000};
    shifted   = m_r_data >> sh_amt;
    lane_mask = ((l_size == 2'b00) ? 32'h0000_00ff : 32'h0000_ffff) << sh_amt;
    merged    = (m_r_data & ~lane_mask) | ((l_wdata << sh_amt) & lane_mask);
    case (l_size)
      2'b00:   load_val = l_uns ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = l_uns ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = m_r_data;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_bad) state_n = RESP;
          else if (req_we && req_size == 2'b10) state_n = WRITE;
          else state_n = READ;
        end
      end
      READ:    state_n = CAPT;
      CAPT:    state_n = l_we ? WRITE : RESP;
      WRITE:   state_n = RESP;
      RESP:    if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Request latch, memory port registers and response registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      l_we       <= 1'b0;
      l_size     <= 2'b00;
      l_uns      <= 1'b0;
      l_lane     <= 2'b00;
      l_wdata    <= 32'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'b0;
      m_addr     <= 32'b0;
      m_w_data   <= 32'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            l_we       <= req_we;
            l_size     <= req_size;
            l_uns      <= req_unsigned;
            l_lane     <= req_addr[1:0];
            l_wdata    <= req_wdata;
            resp_err   <= req_bad;
            resp_rdata <= 32'b0;
            if (!req_bad) begin
              m_addr   <= {{(30-ADDR_W){1'b0}}, req_addr[ADDR_W+1:2]};
              m_w_data <= req_wdata;
            end
          end
        end
        CAPT: begin
          if (l_we) m_w_data   <= merged;
          else      resp_rdata <= load_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_write;
  logic [31:0] m_addr;
  logic [31:0] m_w_data;
  logic [31:0] m_r_data;

  logic [31:0] mem [0:127];

  int n_checks = 0;
  int n_pass   = 0;

  mem_access_unit #(.ADDR_W(7)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_write(mem_write), .m_addr(m_addr), .m_w_data(m_w_data),
    .m_r_data(m_r_data)
  );

  always #5 clk = ~clk;

  // Word memory: registered read, falling-edge write
  always @(posedge clk) m_r_data <= mem[m_addr[6:0]];
  always @(negedge clk) if (mem_write) mem[m_addr[6:0]] <= m_w_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Issue one request; report latency, response and observed writes
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output int wcount, output logic [31:0] waddr);
    wcount = 0;
    waddr  = 32'hffff_ffff;
    resp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_wdata = 32'h5a5a_5a5a; req_addr = 32'hffff_ffff;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      if (mem_write) begin wcount++; waddr = m_addr; end
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) begin
      check("resp_timeout", {31'b0, resp_valid}, 32'd1);
      rdata = 32'hx; err = 1'bx;
    end else begin
      rdata = resp_rdata;
      err   = resp_err;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("bp_valid", {31'b0, resp_valid}, 32'd1);
      check("bp_rdata", resp_rdata, rdata);
      check("bp_ready", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    if (hold > 0) begin
      check("bp_after_valid", {31'b0, resp_valid}, 32'd0);
      check("bp_after_ready", {31'b0, req_ready}, 32'd1);
    end
  endtask

  int          lat, wc;
  logic [31:0] rd, wa, snap;
  logic        er;

  initial begin
    // Reset values
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_err",   {31'b0, resp_err},   32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_write",  {31'b0, mem_write},  32'd0);
    check("rst_m_addr",     m_addr,   32'd0);
    check("rst_m_w_data",   m_w_data, 32'd0);
    check("rst_req_ready",  {31'b0, req_ready},  32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1 check("ready_after_rst", {31'b0, req_ready}, 32'd1);

    // Word round trip
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hdeadbeef, 0, lat, rd, er, wc, wa);
    check("sw_lat", lat, 2);
    check("sw_wcount", wc, 1);
    check("sw_waddr", wa, 32'd4);
    check("sw_err", {31'b0, er}, 32'd0);
    check("sw_rdata", rd, 32'd0);
    check("sw_mem", mem[4], 32'hdeadbeef);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, lat, rd, er, wc, wa);
    check("lw_lat", lat, 3);
    check("lw_rdata", rd, 32'hdeadbeef);
    check("lw_wcount", wc, 0);

    // Byte store merge
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 0, lat, rd, er, wc, wa);
    do_req(1'b1, 2'b00, 1'b0, 32'h22, 32'h000000aa, 0, lat, rd, er, wc, wa);
    check("sb_lat", lat, 4);
    check("sb_wcount", wc, 1);
    check("sb_mem", mem[8], 32'h11aa3344);
    do_req(1'b1, 2'b01, 1'b0, 32'h20, 32'hffff5566, 0, lat, rd, er, wc, wa);
    check("sh_lat", lat, 4);
    check("sh_mem", mem[8], 32'h11aa5566);

    // Extension
    do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'h80ff7f01, 0, lat, rd, er, wc, wa);
    do_req(1'b0, 2'b00, 1'b0, 32'h9, 32'h0, 0, lat, rd, er, wc, wa);
    check("lb_9", rd, 32'h0000007f);
    do_req(1'b0, 2'b00, 1'b0, 32'ha, 32'h0, 0, lat, rd, er, wc, wa);
    check("lb_a", rd, 32'hffffffff);
    check("lb_lat", lat, 3);
    do_req(1'b0, 2'b00, 1'b1, 32'ha, 32'h0, 0, lat, rd, er, wc, wa);
    check("lbu_a", rd, 32'h000000ff);
    do_req(1'b0, 2'b01, 1'b0, 32'ha, 32'h0, 0, lat, rd, er, wc, wa);
    check("lh_a", rd, 32'hffff80ff);
    do_req(1'b0, 2'b01, 1'b1, 32'ha, 32'h0, 0, lat, rd, er, wc, wa);
    check("lhu_a", rd, 32'h000080ff);

    // Errors
    do_req(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 0, lat, rd, er, wc, wa);
    check("err_lw2_lat", lat, 1);
    check("err_lw2_err", {31'b0, er}, 32'd1);
    check("err_lw2_rdata", rd, 32'd0);
    snap = mem[0];
    do_req(1'b1, 2'b01, 1'b0, 32'h1, 32'hbeef, 0, lat, rd, er, wc, wa);
    check("err_sh1_lat", lat, 1);
    check("err_sh1_err", {31'b0, er}, 32'd1);
    check("err_sh1_wcount", wc, 0);
    check("err_sh1_mem", mem[0], snap);
    do_req(1'b1, 2'b11, 1'b0, 32'h10, 32'h0badf00d, 0, lat, rd, er, wc, wa);
    check("err_sz3_lat", lat, 1);
    check("err_sz3_err", {31'b0, er}, 32'd1);
    check("err_sz3_wcount", wc, 0);
    check("err_sz3_mem", mem[4], 32'hdeadbeef);
    do_req(1'b1, 2'b10, 1'b0, 32'h200, 32'h0badf00d, 0, lat, rd, er, wc, wa);
    check("err_oob_lat", lat, 1);
    check("err_oob_err", {31'b0, er}, 32'd1);
    check("err_oob_wcount", wc, 0);
    check("err_oob_mem", mem[0], snap);

    // Backpressure
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 5, lat, rd, er, wc, wa);
    check("bp_rdata_val", rd, 32'h11aa5566);
    do_req(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 0, lat, rd, er, wc, wa);
    check("after_bp_lb", rd, 32'h00000011);

    // Reset in WRITE
    do_req(1'b1, 2'b10, 1'b0, 32'h30, 32'hcafef00d, 0, lat, rd, er, wc, wa);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h30; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b0;
    #1 check("rstw_mem_write", {31'b0, mem_write}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rstw_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rstw_req_ready", {31'b0, req_ready}, 32'd1);
    check("rstw_mem", mem[12], 32'hcafef00d);
    do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 0, lat, rd, er, wc, wa);
    check("rstw_readback", rd, 32'hcafef00d);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator-side load/store engine that sits between the CPU pipeline's memory stage and the word-addressed data memory. It accepts one byte/halfword/word load or store per transaction over a valid/ready handshake, and drives the memory's `mem_write`/`m_addr`/`m_w_data` port. It consumes the memory's one-cycle registered `m_r_data`. Sub-word stores are done as read-modify-write, because the memory only supports whole-word writes.

## Interface
- `ADDR_W`, 7: word-index width; memory depth is 2^ADDR_W words (128).
- `clk` input 1: single clock, rising-edge logic.
- `rst` input 1: reset, synchronous, active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit can accept a request.
- `req_we` input 1: 1 = store, 0 = load.
- `req_size` input 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `req_unsigned` input 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-aligned.
- `resp_valid` output 1: response present.
- `resp_ready` input 1: consumer accepts response.
- `resp_rdata` output 32: extended load data; 0 for stores and errors.
- `resp_err` output 1: request rejected, with no memory access.
- `mem_write` output 1: memory write strobe.
- `m_addr` output 32: word index, equal to `{(30-ADDR_W)'b0, addr[ADDR_W+1:2]}`.
- `m_w_data` output 32: memory write data.
- `m_r_data` input 32: memory read data, valid one clock edge after `m_addr` is presented.

## Operation
- **States:** IDLE, READ, CAPT, WRITE, RESP.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid && req_ready`, latch we, size, unsigned, addr and wdata.
- **Error check at acceptance:** size=11, halfword with addr[0]=1, word with addr[1:0]≠0, or addr[31:ADDR_W+2]≠0.
  - Go to RESP with `resp_err`=1 and `resp_rdata`=0.
  - No memory access.
- **Load:** IDLE→READ→CAPT→RESP.
  - READ drives `m_addr`.
  - CAPT samples `m_r_data` and extracts the lane:
    - byte: lane = addr[1:0];
    - halfword: lane = addr[1];
    - little-endian;
    - sign- or zero-extend per the latched `req_unsigned`.
  - The result is registered into `resp_rdata`.
- **Word store:** IDLE→WRITE→RESP.
- **Sub-word store:** IDLE→READ→CAPT→WRITE→RESP.
  - CAPT merges `req_wdata[7:0]` or `req_wdata[15:0]` into the addressed lane of `m_r_data`.
  - Other bytes are unchanged.
  - The merged word is held in a register.
- **WRITE:** `mem_write`=1 for exactly one cycle, with `m_addr` and `m_w_data` stable for that whole cycle (the memory writes on the falling edge).
- **RESP:**
  - `resp_valid`=1; `resp_rdata` and `resp_err` are held stable until `resp_ready`=1.
  - Then go to IDLE.
  - `req_ready`=0 in every state other than IDLE (one outstanding transaction).
- `m_addr` is held constant from READ/WRITE entry through RESP. It is 0 in IDLE after reset.
- `mem_write` is gated combinationally with `rst`, so a reset asserted during WRITE suppresses that write.

## Timing
- **Reset values** (at the first edge with `rst`=0): state IDLE, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `mem_write`=0, `m_addr`=0, `m_w_data`=0.
- `req_ready`=0 while `rst`=0, and 1 from the first cycle after reset is released.
- **Latency**, counted in cycles from the acceptance edge to `resp_valid` high:
  - error: 1;
  - word store: 2;
  - load: 3;
  - sub-word store: 4.
- **Back-to-back:** the next request can be accepted in the cycle after the response handshake. There is no overlap.
- **Reset mid-transaction:** the unit returns to IDLE at the next edge and drops any pending response. No partial write occurs.
- `resp_ready` held high before RESP is harmless: the handshake completes in the first RESP cycle.
- Request inputs are ignored outside IDLE. Latched values, not live inputs, drive all later states.

## Test plan
- **Word round trip:** sw addr=0x10, data=0xDEADBEEF → `mem_write` high for 1 cycle with `m_addr`=4; then lw 0x10 → `resp_rdata`=0xDEADBEEF, 3 cycles after acceptance.
- **Byte store merge:** with word 0x11223344 at addr 0x20, sb addr=0x22, data=0xAA → memory word becomes 0x11AA3344; response 4 cycles after acceptance.
- **Extension:** memory word 0x80FF7F01 at addr 0x8:
  - lb 0x9 → 0x0000007F;
  - lb 0xA → 0xFFFFFFFF;
  - lbu 0xA → 0x000000FF;
  - lh 0xA → 0xFFFF80FF;
  - lhu 0xA → 0x000080FF.
- **Errors:** each of the following → `resp_err`=1 after 1 cycle, `mem_write` never asserted, memory unchanged:
  - lw 0x2;
  - sh 0x1;
  - size=11;
  - addr 0x200 with ADDR_W=7.
- **Backpressure:** hold `resp_ready`=0 for 5 cycles after `resp_valid` → `resp_rdata` stable and `req_ready`=0 throughout; a new request is accepted the cycle after the handshake.
- **Reset in WRITE:** drive `rst`=0 during the WRITE cycle of sw 0x30, data=0x12345678 → `mem_write` stays 0, the word at 0x30 is unchanged, and the unit is in IDLE with `resp_valid`=0.
